// File: rtl/coef_stream_loader.sv
// coef_stream_loader
//   Moves one polynomial of N_COEFF coefficients between a streaming
//   interface and the CPU memory port of homenc_coprocessor.
//   A load writes the s_* stream into memory at addresses 0..N_COEFF-1.
//   An unload reads the same address range and presents it on the m_* stream.
//   cpu_interrupt holds the coprocessor in CPU-access mode for the whole transfer.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_dir, cmd_mb_sel,            direction (0 load, 1 unload), bank select,
//   cmd_mem_sel                     and memory select
//   s_valid/s_ready/s_data          load input stream
//   m_valid/m_ready/m_data/m_last   unload output stream (m_last on final word)
//   cpu_interrupt, cpu_mb_sel,      coprocessor CPU memory bus
//   cpu_mem_sel, cpu_mem_addr,
//   cpu_mem_wr_data, cpu_mem_wr_en
//   cpu_mem_rd_data                 read data, valid one cycle after its address
//   busy, done                      transfer in progress / one-cycle completion pulse
module coef_stream_loader #(
  parameter int N_COEFF = 2048,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [2:0]        cmd_mb_sel,
  input  logic [3:0]        cmd_mem_sel,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              cpu_interrupt,
  output logic [2:0]        cpu_mb_sel,
  output logic [3:0]        cpu_mem_sel,
  output logic [ADDR_W-1:0] cpu_mem_addr,
  output logic [DATA_W-1:0] cpu_mem_wr_data,
  output logic              cpu_mem_wr_en,
  input  logic [DATA_W-1:0] cpu_mem_rd_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, UNLOAD, RELEASE} state_t;

  localparam logic [ADDR_W:0] N_FULL = (ADDR_W + 1)'(N_COEFF);

  state_t            state_reg, state_next;
  logic              dir_reg;
  logic [2:0]        mb_sel_reg;
  logic [3:0]        mem_sel_reg;
  logic [ADDR_W:0]   wr_cnt_reg;
  logic [ADDR_W:0]   rd_cnt_reg;
  logic [ADDR_W:0]   out_cnt_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              rd_pending_reg;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_head_reg;
  logic [1:0]        fifo_cnt_reg;

  logic       cmd_fire, s_fire, pop, issue, push, fifo_pop, fifo_empty;
  logic [2:0] occ;

  assign fifo_empty = (fifo_cnt_reg == 2'd0);

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  assign cmd_ready = rst_n && (state_reg == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign s_ready   = (state_reg == LOAD) && (wr_cnt_reg < N_FULL);
  assign s_fire    = s_valid && s_ready;

  // The output FIFO falls through: when it is empty, the word returning from
  // memory this cycle goes straight to m_data. That gives the first word one
  // cycle after its address and full throughput with m_ready held high.
  assign m_valid = (state_reg == UNLOAD) && (!fifo_empty || rd_pending_reg);
  assign m_data  = !m_valid   ? '0 :
                   fifo_empty ? cpu_mem_rd_data : fifo_mem[fifo_head_reg];
  assign m_last  = m_valid && (out_cnt_reg == N_FULL - 1'b1);
  assign pop     = m_valid && m_ready;

  // Count every word that will hold a FIFO slot: stored words plus the read
  // returning now, minus the word leaving now. A new read is issued only
  // while that count is below the FIFO depth, so backpressure never drops data.
  assign occ      = {1'b0, fifo_cnt_reg} + {2'b00, rd_pending_reg} - {2'b00, pop};
  assign issue    = (state_reg == UNLOAD) && (rd_cnt_reg < N_FULL) && (occ < 3'd2);
  assign push     = rd_pending_reg && !(fifo_empty && pop);
  assign fifo_pop = pop && !fifo_empty;

  assign cpu_interrupt   = (state_reg == SETUP) || (state_reg == LOAD) || (state_reg == UNLOAD);
  assign cpu_mb_sel      = mb_sel_reg;
  assign cpu_mem_sel     = mem_sel_reg;
  assign cpu_mem_addr    = (state_reg == UNLOAD) ? rd_cnt_reg[ADDR_W-1:0] : wr_addr_reg;
  assign cpu_mem_wr_data = wr_data_reg;
  assign cpu_mem_wr_en   = wr_en_reg;
  assign busy            = (state_reg != IDLE) && (state_reg != RELEASE);
  assign done            = (state_reg == RELEASE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire) state_next = SETUP;
      SETUP:   state_next = dir_reg ? UNLOAD : LOAD;
      // Stay in LOAD one cycle after the last handshake so the final
      // registered write is still inside the transfer window.
      LOAD:    if (wr_cnt_reg == N_FULL) state_next = RELEASE;
      UNLOAD:  if (pop && m_last) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      dir_reg        <= 1'b0;
      mb_sel_reg     <= '0;
      mem_sel_reg    <= '0;
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      out_cnt_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      rd_pending_reg <= 1'b0;
      fifo_head_reg  <= 1'b0;
      fifo_cnt_reg   <= '0;
      fifo_mem[0]    <= '0;
      fifo_mem[1]    <= '0;
    end else begin
      state_reg <= state_next;

      if (cmd_fire) begin
        dir_reg     <= cmd_dir;
        mb_sel_reg  <= cmd_mb_sel;
        mem_sel_reg <= cmd_mem_sel;
        wr_cnt_reg  <= '0;
        rd_cnt_reg  <= '0;
        out_cnt_reg <= '0;
      end else begin
        if (s_fire) wr_cnt_reg  <= wr_cnt_reg + 1'b1;
        if (issue)  rd_cnt_reg  <= rd_cnt_reg + 1'b1;
        if (pop)    out_cnt_reg <= out_cnt_reg + 1'b1;
      end

      wr_en_reg <= s_fire;
      if (s_fire) begin
        wr_addr_reg <= wr_cnt_reg[ADDR_W-1:0];
        wr_data_reg <= s_data;
      end

      rd_pending_reg <= issue;

      // Tail slot is head ^ count; a push and a pop never collide on a
      // full FIFO because issue kept the total at or below two.
      if (push) fifo_mem[fifo_head_reg ^ fifo_cnt_reg[0]] <= cpu_mem_rd_data;
      if (fifo_pop) fifo_head_reg <= ~fifo_head_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

endmodule

// File: tb/tb_coef_stream_loader.sv
// tb_coef_stream_loader
//   Randomized scoreboard bench for coef_stream_loader. The stimulus process
//   pushes expected memory writes and expected output words into queues. A
//   monitor process pops and compares them whenever the DUT writes memory or
//   hands over a stream word. A simple memory model stands in for the
//   coprocessor.
`timescale 1ns/1ps
module tb_coef_stream_loader;
  localparam int N  = 2048;
  localparam int AW = 11;
  localparam int DW = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
  logic [2:0]    cmd_mb_sel = '0;
  logic [3:0]    cmd_mem_sel = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0, m_last;
  logic [DW-1:0] m_data;
  logic          cpu_interrupt, cpu_mem_wr_en, busy, done;
  logic [2:0]    cpu_mb_sel;
  logic [3:0]    cpu_mem_sel;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_mem_wr_data, cpu_mem_rd_data;

  coef_stream_loader #(.N_COEFF(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_mb_sel(cmd_mb_sel), .cmd_mem_sel(cmd_mem_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cpu_interrupt(cpu_interrupt), .cpu_mb_sel(cpu_mb_sel), .cpu_mem_sel(cpu_mem_sel),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wr_data(cpu_mem_wr_data),
    .cpu_mem_wr_en(cpu_mem_wr_en), .cpu_mem_rd_data(cpu_mem_rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial memory content: bank 3 holds 0xABC0000 + address, everything else 0.
  function automatic logic [DW-1:0] init_val(input logic [2:0] mb, input int a);
    return (mb == 3'd3) ? DW'(32'h0ABC_0000 + a) : '0;
  endfunction

  // Coprocessor memory model: writes land at the clock edge, reads return one cycle later.
  logic [DW-1:0] bus_mem [bit [17:0]];
  logic [DW-1:0] rd_q = '0;
  assign cpu_mem_rd_data = rd_q;
  always @(posedge clk) begin
    bit [17:0] k;
    k = {cpu_mb_sel, cpu_mem_sel, cpu_mem_addr};
    rd_q <= bus_mem.exists(k) ? bus_mem[k] : init_val(cpu_mb_sel, int'(cpu_mem_addr));
    if (cpu_mem_wr_en) bus_mem[k] = cpu_mem_wr_data;
  end

  // Reference memory: what each polynomial must contain after the loads so far.
  logic [DW-1:0] ref_mem [bit [17:0]];
  function automatic logic [DW-1:0] ref_val(input logic [2:0] mb, input logic [3:0] ms, input int a);
    bit [17:0] k;
    k = {mb, ms, AW'(a)};
    return ref_mem.exists(k) ? ref_mem[k] : init_val(mb, a);
  endfunction

  typedef struct packed {
    logic [2:0]    mb;
    logic [3:0]    ms;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  int checks = 0, errors = 0;
  int wr_seen, rd_seen, done_cnt;
  int first_wr, last_wr, first_m, last_m, done_cyc;
  int m_mode = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT produces something.
  initial begin
    wr_t w;
    rd_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_mem_wr_en) begin
          wr_seen++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
          chk("wr_irq", cpu_interrupt, 1);
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            w = exp_wr.pop_front();
            chk("wr_bus", {cpu_mb_sel, cpu_mem_sel, cpu_mem_addr, cpu_mem_wr_data}, w);
          end
        end
        if (m_valid && m_ready) begin
          rd_seen++;
          if (first_m < 0) first_m = cyc;
          last_m = cyc;
          if (exp_rd.size() == 0) chk("m_unexpected", 1, 0);
          else begin
            r = exp_rd.pop_front();
            chk("m_word", {m_data, m_last}, r);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_idle", {busy, cpu_interrupt, cpu_mem_wr_en}, 3'b000);
        end
      end
    end
  end

  // Output backpressure: mode 0 always ready, mode 1 ready 2 cycles out of every 7.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = (m_mode == 0) ? 1'b1 : ((cyc % 7) < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_seen = 0; rd_seen = 0; done_cnt = 0;
    first_wr = -1; last_wr = -1; first_m = -1; last_m = -1; done_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {s_ready, m_valid, m_last, m_data, cpu_interrupt, cpu_mb_sel, cpu_mem_sel,
               cpu_mem_addr, cpu_mem_wr_data, cpu_mem_wr_en, busy, done}, '0);
  endtask

  task automatic issue_cmd(input bit dir, input logic [2:0] mb, input logic [3:0] ms, output int c);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    clear_mon();
    cmd_valid = 1'b1; cmd_dir = dir; cmd_mb_sel = mb; cmd_mem_sel = ms;
    c = cyc;
    tick();
    cmd_valid = 1'b0;
    chk("setup_state", {cpu_interrupt, busy, cmd_ready, s_ready, cpu_mb_sel, cpu_mem_sel},
        {1'b1, 1'b1, 1'b0, 1'b0, mb, ms});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cyc < 0 && n < budget) begin tick(); n++; end
    chk("done_seen", done_cyc >= 0, 1);
    tick();
    chk("done_single", done_cnt, 1);
  endtask

  // mode 0: ramp data, s_valid held high; mode 1: random data and gaps,
  // plus a competing command mid-transfer. abort_at > 0 resets after that many words.
  task automatic run_load(input logic [2:0] mb, input logic [3:0] ms, input int mode, input int abort_at);
    int c, i, guard;
    logic [DW-1:0] d;
    i = 0; guard = 0;
    issue_cmd(1'b0, mb, ms, c);
    while (i < N && guard < 20000) begin
      s_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      d = (mode == 0) ? DW'(i) : DW'({$urandom, $urandom});
      s_data = d;
      if (mode == 1 && i >= 500 && i < 503) begin
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_mb_sel = ~mb; cmd_mem_sel = ~ms;
        chk("cmd_ready_busy", cmd_ready, 0);
      end else cmd_valid = 1'b0;
      if (s_valid && s_ready) begin
        exp_wr.push_back({mb, ms, AW'(i), d});
        ref_mem[{mb, ms, AW'(i)}] = d;
        i++;
      end
      tick();
      guard++;
      if (abort_at > 0 && i == abort_at) break;
    end
    s_valid = 1'b0; cmd_valid = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_load");
      chk("reset_cmd_ready", cmd_ready, 0);
      exp_wr.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_cmd_ready", cmd_ready, 1);
      $display("load  mb=%0d ms=%0d aborted by reset after %0d words", mb, ms, i);
      return;
    end
    wait_done(200);
    chk("load_wr_count", wr_seen, N);
    chk("load_queue_empty", exp_wr.size(), 0);
    chk("load_done_timing", done_cyc, last_wr + 1);
    if (mode == 0) begin
      chk("load_first_wr", first_wr, c + 3);
      chk("load_consecutive", last_wr - first_wr, N - 1);
    end
    $display("load  mb=%0d ms=%0d mode=%0d cmd@%0d writes=%0d first=%0d last=%0d done@%0d",
             mb, ms, mode, c, wr_seen, first_wr, last_wr, done_cyc);
  endtask

  task automatic run_unload(input logic [2:0] mb, input logic [3:0] ms, input int bp);
    int c;
    m_mode = bp;
    for (int i = 0; i < N; i++) exp_rd.push_back({ref_val(mb, ms, i), i == N - 1});
    issue_cmd(1'b1, mb, ms, c);
    wait_done(20000);
    chk("unload_count", rd_seen, N);
    chk("unload_queue_empty", exp_rd.size(), 0);
    chk("unload_done_timing", done_cyc, last_m + 1);
    if (bp == 0) begin
      chk("unload_first_word", first_m, c + 3);
      chk("unload_last_word", last_m, c + 2050);
      chk("unload_done_cycle", done_cyc, c + 2051);
    end
    exp_rd.delete();
    m_mode = 0;
    $display("unload mb=%0d ms=%0d bp=%0d cmd@%0d words=%0d first=%0d last=%0d done@%0d",
             mb, ms, bp, c, rd_seen, first_m, last_m, done_cyc);
  endtask

  initial begin
    int mism;
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    chk("reset_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", cmd_ready, 1);
    check_reset_outputs("release_outputs");
    tick();

    run_load(3'd0, 4'd4, 0, 0);
    mism = 0;
    for (int i = 0; i < N; i++) begin
      bit [17:0] k;
      k = {3'd0, 4'd4, AW'(i)};
      if (!bus_mem.exists(k) || bus_mem[k] !== DW'(i)) mism++;
    end
    chk("ramp_readback", mism, 0);

    run_load(3'd1, 4'd7, 1, 0);
    run_unload(3'd3, 4'd2, 0);
    run_unload(3'd1, 4'd7, 1);
    run_load(3'd2, 4'd1, 0, 100);
    run_load(3'd2, 4'd1, 0, 0);
    run_unload(3'd0, 4'd4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/coef_stream_loader.md
# coef_stream_loader

Host-side loader/unloader placed directly upstream of `homenc_coprocessor`'s CPU memory port. It accepts a command (direction, memory bank, memory select), then either writes a 2048-coefficient polynomial from an input stream into the coprocessor memory or reads one out to an output stream. It drives the `cpu_interrupt` / `cpu_mb_sel` / `cpu_mem_*` bus, replacing hand-sequenced host writes.

## Interface
- `N_COEFF`, 2048, coefficients per transfer; power of two.
- `ADDR_W`, 11, `log2(N_COEFF)`; width of `cpu_mem_addr`.
- `DATA_W`, 60, coefficient width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_dir`  in  1  0 = load (stream to memory), 1 = unload (memory to stream).
- `cmd_mb_sel`  in  3  memory bank select.
- `cmd_mem_sel`  in  4  memory select.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in DATA_W: load input stream.
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out DATA_W / `m_last` out 1: unload output stream.
- `cpu_interrupt`  out  1  holds the coprocessor in CPU-access mode.
- `cpu_mb_sel` out 3, `cpu_mem_sel` out 4, `cpu_mem_addr` out ADDR_W, `cpu_mem_wr_data` out DATA_W, `cpu_mem_wr_en` out 1: memory bus.
- `cpu_mem_rd_data`  in  DATA_W  read data; valid exactly 1 cycle after its address is driven.
- `busy`  out  1  high from command accept until `done`.
- `done`  out  1  single-cycle pulse when a transfer finishes.

## Operation
- FSM states: IDLE, SETUP, LOAD, UNLOAD, RELEASE.
- IDLE: `cmd_ready`=1. On `cmd_valid` & `cmd_ready`, latch dir/mb_sel/mem_sel into `cpu_mb_sel`/`cpu_mem_sel`, clear counters, set `busy`, go to SETUP.
- SETUP: one cycle. `cpu_interrupt`=1, no memory access. Go to LOAD or UNLOAD according to dir.
- LOAD: `s_ready`=1 while `wr_cnt` < N_COEFF.
  - Each `s_valid` & `s_ready` registers `cpu_mem_wr_en`=1, `cpu_mem_addr`=`wr_cnt`, `cpu_mem_wr_data`=`s_data`, then increments `wr_cnt`.
  - A cycle with no handshake registers `cpu_mem_wr_en`=0.
  - After the N_COEFF-th handshake, drop `s_ready` and go to RELEASE.
- UNLOAD: issue reads at addresses 0..N_COEFF-1 in order, driving `cpu_mem_addr`=`rd_cnt`.
  - Returned data goes into a 2-entry output FIFO that feeds `m_data`/`m_valid`.
  - Issue a read only if (FIFO occupancy + reads in flight − pop this cycle) < 2. No word is ever dropped under backpressure.
  - `m_last`=1 with word N_COEFF-1.
  - When the last word is popped (`m_valid` & `m_ready` & `m_last`), go to RELEASE.
- RELEASE: one cycle with `cpu_interrupt`=0, `cpu_mem_wr_en`=0, `done`=1, `busy`=0. Then IDLE.
- Counters are ADDR_W+1 bits wide, so reaching N_COEFF is distinguishable from 0 and the address never wraps within a transfer.
- `cpu_mem_wr_en` is never 1 outside LOAD plus one trailing cycle. `cpu_interrupt` is 1 only in SETUP/LOAD/UNLOAD.
- `cmd_valid` while busy is ignored: `cmd_ready`=0 and no command is latched.
- Reset mid-transfer: all state and outputs return immediately to reset values; the partial transfer is abandoned and the FIFO is flushed.

## Timing
- Reset values: `cmd_ready`=0 while `rst_n`=0, 1 after release. All other outputs (`s_ready`, `m_valid`, `m_last`, `m_data`, `cpu_*`, `busy`, `done`) are 0.
- Command accept at cycle C: SETUP at C+1 (`cpu_interrupt` rises, `busy`=1). LOAD/UNLOAD from C+2.
- Load: `s_data` accepted at cycle T appears on `cpu_mem_wr_data` with `cpu_mem_wr_en`=1 at T+1.
  - With `s_valid` held high, 2048 writes occupy 2048 consecutive cycles.
  - `done` pulses the cycle after the final write-enable cycle.
- Unload: address driven at T; data enters the FIFO at T+1; `m_valid` at T+1 at the earliest.
  - With `m_ready` held high, throughput is 1 word/cycle.
  - First word arrives at C+3; `m_last` at C+2050; `done` at C+2051.
- `done` and `busy` are never both 1.

## Test plan
- Load ramp: cmd (dir=0, mb_sel=0, mem_sel=4), `s_data`=i for i=0..2047 with `s_valid` always high -> 2048 consecutive writes with addr=i, data=i. `cpu_interrupt` high exactly SETUP..last write. `done` 1 cycle. Memory readback matches.
- Load with gaps: `s_valid` toggled in a pseudo-random pattern -> `cpu_mem_wr_en`=0 on idle cycles, addresses still contiguous 0..2047, no duplicates.
- Unload full speed: preload bank 3 with value 0xABC0000+i, cmd dir=1, `m_ready`=1 -> `m_data` sequence 0xABC0000..+2047, one per cycle, `m_last` only on the final word.
- Unload backpressure: `m_ready` low for 5 cycles every 7 -> no loss, no duplication, FIFO never exceeds 2 entries, order preserved.
- Reset mid-load: assert `rst_n`=0 after 100 writes -> all outputs 0 immediately. A new load then restarts at addr 0.
- Command during busy: `cmd_valid` pulsed mid-transfer -> `cmd_ready`=0, and the current transfer's `mb_sel`/`mem_sel` are unchanged.
